// File: rtl/ysyx_23060077_mdu_pkg.sv
// Shared constants and types for the RV32M multiply/divide sequencer.
// Holds state encodings, funct3 codes and the latched op descriptor.
package ysyx_23060077_mdu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CNT_WIDTH  = 5;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_BUSY = 2'b01,
    MDU_SIGN = 2'b10,
    MDU_DONE = 2'b11
  } mdu_state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef struct packed {
    logic       is_div;
    logic [2:0] funct3;
    logic       neg_a;
    logic       neg_b;
  } mdu_op_t;

  function automatic logic [DATA_WIDTH-1:0] mag(
    input logic                  neg,
    input logic [DATA_WIDTH-1:0] v
  );
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/ysyx_23060077_mdu_iter.sv
// One radix-2 step: shift/add for multiply, shift/subtract/restore for divide.
// acc is {hi, lo}: product/remainder in hi, multiplier/quotient in lo.
module ysyx_23060077_mdu_iter
  import ysyx_23060077_mdu_pkg::*;
(
  input  logic                    is_div,
  input  logic [2*DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0]   opnd,
  output logic [2*DATA_WIDTH-1:0] acc_next
);

  localparam int W = DATA_WIDTH;

  logic [W:0]   sum;
  logic [W:0]   trial;
  logic [W-1:0] diff;
  logic         ge;

  always_comb begin
    sum   = {1'b0, acc[2*W-1:W]}
          + (acc[0] ? {1'b0, opnd} : '0);
    trial = {acc[2*W-1:W], acc[W-1]};
    ge    = trial >= {1'b0, opnd};
    // only consumed when ge, so the result fits in W bits
    diff  = trial[W-1:0] - opnd;
    if (is_div) begin
      acc_next = {ge ? diff : trial[W-1:0],
                  acc[W-2:0], ge};
    end else begin
      acc_next = {sum, acc[W-1:1]};
    end
  end

endmodule

// File: rtl/ysyx_23060077_mdu_ctrl.sv
// Multi-cycle RV32M sequencer: 32 shared iterations, sign fix-up, handshake.
// Divide-by-zero and signed overflow bypass the iterations entirely.
module ysyx_23060077_mdu_ctrl
  import ysyx_23060077_mdu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  alu_mul,
  input  logic                  alu_div,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy
);

  localparam int W = DATA_WIDTH;

  mdu_state_e           state;
  mdu_state_e           state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [2*W-1:0]       acc;
  logic [2*W-1:0]       acc_nxt;
  logic [W-1:0]         opnd;
  mdu_op_t              op;
  mdu_op_t              op_in;

  logic         accept;
  logic         a_signed;
  logic         b_signed;
  logic         div_zero;
  logic         div_ovf;
  logic         fast;
  logic [W-1:0] mag_a;
  logic [W-1:0] mag_b;
  logic [W-1:0] fast_res;
  logic [W-1:0] fix_res;
  logic [2*W-1:0] prod;
  logic         mul_lo;
  logic         mul_hi;
  logic         is_rem;
  logic         is_quo;

  assign accept = in_valid & in_ready
                & (alu_mul ^ alu_div) & ~flush;

  always_comb begin
    a_signed = alu_mul
      ? (funct3 == F3_MULH || funct3 == F3_MULHSU)
      : ~funct3[0];
    b_signed = alu_mul
      ? (funct3 == F3_MULH)
      : ~funct3[0];
    op_in.is_div = alu_div;
    op_in.funct3 = funct3;
    op_in.neg_a  = a_signed & src1[W-1];
    op_in.neg_b  = b_signed & src2[W-1];
    mag_a = mag(op_in.neg_a, src1);
    mag_b = mag(op_in.neg_b, src2);
  end

  always_comb begin
    div_zero = alu_div && (src2 == '0);
    div_ovf  = alu_div && !funct3[0]
            && (src1 == {1'b1, {(W-1){1'b0}}})
            && (src2 == '1);
    fast     = div_zero | div_ovf;
    fast_res = '0;
    if (div_zero) begin
      fast_res = funct3[1] ? src1 : '1;
    end else if (div_ovf) begin
      fast_res = funct3[1] ? '0 : {1'b1, {(W-1){1'b0}}};
    end
  end

  ysyx_23060077_mdu_iter u_iter (
    .is_div   (op.is_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_nxt)
  );

  always_comb begin
    prod   = (op.neg_a ^ op.neg_b) ? -acc : acc;
    mul_lo = !op.is_div && (op.funct3 == F3_MUL);
    mul_hi = !op.is_div && (op.funct3 != F3_MUL);
    is_rem = op.is_div && op.funct3[1];
    is_quo = op.is_div && !op.funct3[1];
    fix_res = '0;
    unique case (1'b1)
      mul_lo: fix_res = prod[W-1:0];
      mul_hi: fix_res = prod[2*W-1:W];
      is_rem: fix_res = mag(op.neg_a, acc[2*W-1:W]);
      is_quo: fix_res = mag(op.neg_a ^ op.neg_b,
                            acc[W-1:0]);
      default: fix_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= MDU_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      MDU_IDLE: begin
        if (accept) begin
          state_nxt = fast ? MDU_DONE : MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        if (flush) begin
          state_nxt = MDU_IDLE;
        end else if (cnt == '1) begin
          state_nxt = MDU_SIGN;
        end
      end
      MDU_SIGN: begin
        state_nxt = flush ? MDU_IDLE : MDU_DONE;
      end
      MDU_DONE: begin
        if (flush || out_ready) begin
          state_nxt = MDU_IDLE;
        end
      end
      default: state_nxt = MDU_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == MDU_IDLE);
    busy      = (state != MDU_IDLE);
    out_valid = (state == MDU_DONE);
  end

  // multiplier / dividend goes in lo, multiplicand / divisor in opnd
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      op     <= '0;
      result <= '0;
    end else if (accept) begin
      cnt  <= '0;
      op   <= op_in;
      acc  <= {{W{1'b0}}, alu_div ? mag_a : mag_b};
      opnd <= alu_div ? mag_b : mag_a;
      if (fast) begin
        result <= fast_res;
      end
    end else if (state == MDU_BUSY && !flush) begin
      acc <= acc_nxt;
      cnt <= cnt + CNT_WIDTH'(1);
    end else if (state == MDU_SIGN && !flush) begin
      result <= fix_res;
    end
  end

endmodule

// File: tb/tb_ysyx_23060077_mdu_ctrl.sv
// Directed bench for the RV32M sequencer.
// Hand-computed vectors, latency, handshake, flush and reset cases.
module tb_ysyx_23060077_mdu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        alu_mul;
  logic        alu_div;
  logic [2:0]  funct3;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ysyx_23060077_mdu_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_mul   (alu_mul),
    .alu_div   (alu_div),
    .funct3    (funct3),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic m, input logic d,
                         input logic [2:0] f3,
                         input logic [31:0] a,
                         input logic [31:0] b);
    in_valid = 1'b1;
    alu_mul  = m;
    alu_div  = d;
    funct3   = f3;
    src1     = a;
    src2     = b;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    alu_mul  = 1'b0;
    alu_div  = 1'b0;
  endtask

  // accept edge is counted as edge 1
  task automatic wait_done(output int lat,
                           output logic rdy_seen);
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      step();
      lat++;
    end
  endtask

  task automatic run_op(input string tag,
                        input logic m, input logic d,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int exp_lat,
                        input logic [31:0] exp_res);
    int   lat;
    logic rdy_seen;
    present(m, d, f3, a, b);
    step();
    idle_in();
    wait_done(lat, rdy_seen);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " result"}, result, exp_res);
    chk({tag, " in_ready busy"}, {31'd0, rdy_seen}, 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, " idle after hs"},
        {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    int   lat;
    logic rdy_seen;
    logic bad;
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    funct3 = 3'd0;
    src1 = 32'd0;
    src2 = 32'd0;
    idle_in();
    step();
    step();
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset result", result, 32'd0);
    rst_n = 1'b1;
    step();

    run_op("MUL", 1, 0, 3'b000, 32'd7, 32'hFFFFFFFD,
           34, 32'hFFFFFFEB);
    run_op("MULHU", 1, 0, 3'b011, 32'hFFFFFFFF,
           32'hFFFFFFFF, 34, 32'hFFFFFFFE);
    run_op("MULH", 1, 0, 3'b001, 32'hFFFFFFFF,
           32'hFFFFFFFF, 34, 32'h00000000);
    run_op("MULHSU", 1, 0, 3'b010, 32'hFFFFFFFF,
           32'd2, 34, 32'hFFFFFFFF);
    run_op("DIV", 0, 1, 3'b100, 32'hFFFFFFF9,
           32'd2, 34, 32'hFFFFFFFD);
    run_op("REM", 0, 1, 3'b110, 32'hFFFFFFF9,
           32'd2, 34, 32'hFFFFFFFF);
    run_op("DIVU", 0, 1, 3'b101, 32'd100, 32'd7,
           34, 32'd14);
    run_op("REMU", 0, 1, 3'b111, 32'd100, 32'd7,
           34, 32'd2);
    run_op("DIV0", 0, 1, 3'b100, 32'd5, 32'd0,
           1, 32'hFFFFFFFF);
    run_op("REM0", 0, 1, 3'b110, 32'd5, 32'd0,
           1, 32'd5);
    run_op("DIVOVF", 0, 1, 3'b100, 32'h80000000,
           32'hFFFFFFFF, 1, 32'h80000000);
    run_op("REMOVF", 0, 1, 3'b110, 32'h80000000,
           32'hFFFFFFFF, 1, 32'd0);

    present(1, 1, 3'b000, 32'd3, 32'd5);
    step();
    chk("both flags ignored", {31'd0, busy}, 32'd0);
    present(0, 0, 3'b000, 32'd3, 32'd5);
    step();
    chk("no flag ignored", {31'd0, busy}, 32'd0);
    present(1, 0, 3'b000, 32'd3, 32'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle_in();
    chk("idle flush blocks", {31'd0, busy}, 32'd0);

    // consumer stall in DONE with a new op waiting
    present(0, 1, 3'b101, 32'd100, 32'd7);
    step();
    idle_in();
    wait_done(lat, rdy_seen);
    chk("stall latency", 32'(lat), 32'd34);
    present(1, 0, 3'b000, 32'd3, 32'd5);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (result !== 32'd14 || !out_valid || in_ready)
        bad = 1'b1;
    end
    chk("stall hold", {31'd0, bad}, 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hs no same-cycle accept",
        {30'd0, in_ready, busy}, 32'd2);
    step();
    idle_in();
    chk("accept after hs", {31'd0, busy}, 32'd1);
    wait_done(lat, rdy_seen);
    chk("queued MUL latency", 32'(lat), 32'd34);
    chk("queued MUL result", result, 32'd15);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // flush during iteration 12
    present(1, 0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step();
    idle_in();
    for (int i = 0; i < 11; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush busy", {30'd0, busy, out_valid}, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid || busy) bad = 1'b1;
    end
    chk("flush no result", {31'd0, bad}, 32'd0);
    run_op("MUL post flush", 1, 0, 3'b000, 32'd12,
           32'd11, 34, 32'd132);

    // reset during iteration 20
    present(0, 1, 3'b100, 32'hFFFFFF9C, 32'd7);
    step();
    idle_in();
    for (int i = 0; i < 19; i++) step();
    rst_n = 1'b0;
    flush = 1'b1;
    step();
    rst_n = 1'b1;
    flush = 1'b0;
    chk("mid reset state",
        {30'd0, in_ready, busy}, 32'd2);
    chk("mid reset result", result, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) bad = 1'b1;
    end
    chk("reset no result", {31'd0, bad}, 32'd0);
    run_op("DIV post reset", 0, 1, 3'b100, 32'hFFFFFF9C,
           32'd7, 34, 32'hFFFFFFF2);

    // flush drops a finished result
    present(0, 1, 3'b100, 32'd5, 32'd0);
    step();
    idle_in();
    chk("fast done", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("done flush", {30'd0, in_ready, out_valid},
        32'd2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
